// File: rtl/fp_mul_pkg.sv
// Shared FloatMul definitions: exponent-sequencer state encoding, KPG carry codes
// and FP16 exponent constants.
package fp_mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_BIAS = 2'd2,
        ST_HOLD = 2'd3
    } exp_state_e;

    localparam logic [1:0] KPG_KILL = 2'b00;
    localparam logic [1:0] KPG_GEN  = 2'b01;
    localparam logic [1:0] KPG_PROP = 2'b10;

    localparam int EXP_W   = 5;
    localparam int EXP_MAX = 31;

    // Prefix operator: a propagating upper group defers to the lower group.
    function automatic logic [1:0] kpg_combine(input logic [1:0] hi, input logic [1:0] lo);
        return hi[1] ? lo : hi;
    endfunction

endpackage

// File: rtl/sum5bit.sv
// 5-bit Kogge-Stone KPG prefix adder with a KPG-coded carry-in; sum[5] is the carry-out.
module sum5bit
    import fp_mul_pkg::*;
(
    input  logic [4:0] a,
    input  logic [4:0] b,
    input  logic [1:0] kIn,
    output logic [5:0] sum
);

    // Element 0 is the carry-in, element i+1 the KPG code of bit i.
    logic [1:0] lvl0 [6];
    logic [1:0] lvl1 [6];
    logic [1:0] lvl2 [6];
    logic [1:0] lvl3 [6];
    logic [5:0] carry;

    always_comb begin
        lvl0[0] = kIn;
        for (int i = 0; i < 5; i++) begin
            if (a[i] & b[i])
                lvl0[i+1] = KPG_GEN;
            else if (a[i] | b[i])
                lvl0[i+1] = KPG_PROP;
            else
                lvl0[i+1] = KPG_KILL;
        end

        lvl1[0] = lvl0[0];
        for (int j = 1; j < 6; j++) lvl1[j] = kpg_combine(lvl0[j], lvl0[j-1]);

        for (int j = 0; j < 2; j++) lvl2[j] = lvl1[j];
        for (int j = 2; j < 6; j++) lvl2[j] = kpg_combine(lvl1[j], lvl1[j-2]);

        for (int j = 0; j < 4; j++) lvl3[j] = lvl2[j];
        for (int j = 4; j < 6; j++) lvl3[j] = kpg_combine(lvl2[j], lvl2[j-4]);

        // Every prefix is anchored at the resolved carry-in, so no propagate code survives.
        for (int j = 0; j < 6; j++) carry[j] = (lvl3[j] == KPG_GEN);

        for (int i = 0; i < 5; i++) sum[i] = a[i] ^ b[i] ^ carry[i];
        sum[5] = carry[5];
    end

endmodule

// File: rtl/fp_exp_add_ctrl.sv
// FP16 multiply result-exponent sequencer: two passes through one shared sum5bit
// (ea+eb, then +NBIAS+norm_inc) with overflow/underflow detection and saturation.
module fp_exp_add_ctrl
    import fp_mul_pkg::*;
#(
    parameter int BIAS = 15,
    parameter bit SAT  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [EXP_W-1:0] exp_a,
    input  logic [EXP_W-1:0] exp_b,
    input  logic             norm_inc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [EXP_W-1:0] exp_out,
    output logic             overflow,
    output logic             underflow
);

    localparam logic [EXP_W-1:0] NBIAS = EXP_W'(32 - BIAS);

    exp_state_e       state_q, state_d;
    logic [EXP_W-1:0] ea_q, eb_q;
    logic             inc_q;
    logic [5:0]       s6_q;
    logic [EXP_W-1:0] exp_q;
    logic             ovf_q, unf_q;

    logic [EXP_W-1:0] add_a, add_b;
    logic [1:0]       add_k;
    logic [5:0]       add_sum;
    logic             accept;
    logic             ovf_c, unf_c;

    function automatic logic [EXP_W-1:0] sat_exp(input logic [5:0] p6, input logic ovf,
                                                 input logic unf);
        if (SAT && ovf) return EXP_W'(EXP_MAX);
        if (SAT && unf) return '0;
        return p6[EXP_W-1:0];
    endfunction

    always_comb begin
        add_a = ea_q;
        add_b = eb_q;
        add_k = KPG_KILL;
        if (state_q == ST_BIAS) begin
            add_a = s6_q[EXP_W-1:0];
            add_b = NBIAS;
            add_k = {1'b0, inc_q};
        end
    end

    sum5bit u_sum (
        .a   (add_a),
        .b   (add_b),
        .kIn (add_k),
        .sum (add_sum)
    );

    // True exponent T = p6 - 32 + 32*s6[5]; flag against T >= 31 and T <= 0.
    always_comb begin
        ovf_c = 1'b0;
        unf_c = 1'b0;
        if (s6_q[5]) begin
            ovf_c = (add_sum >= 6'd31);
        end else begin
            unf_c = (add_sum <= 6'd32);
            ovf_c = (add_sum == 6'd63);
        end
    end

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_HOLD) && out_ready);
    assign out_valid = (state_q == ST_HOLD);
    assign accept    = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (accept) state_d = ST_ADD;
            ST_ADD:  state_d = ST_BIAS;
            ST_BIAS: state_d = ST_HOLD;
            ST_HOLD: if (out_ready) state_d = in_valid ? ST_ADD : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            ea_q    <= '0;
            eb_q    <= '0;
            inc_q   <= 1'b0;
            s6_q    <= '0;
            exp_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                ea_q  <= exp_a;
                eb_q  <= exp_b;
                inc_q <= norm_inc;
            end
            if (state_q == ST_ADD) s6_q <= add_sum;
            if (state_q == ST_BIAS) begin
                exp_q <= sat_exp(add_sum, ovf_c, unf_c);
                ovf_q <= ovf_c;
                unf_q <= unf_c;
            end
        end
    end

    assign exp_out   = exp_q;
    assign overflow  = ovf_q;
    assign underflow = unf_q;

endmodule

// File: tb/tb_fp_exp_add_ctrl.sv
// Bench for fp_exp_add_ctrl: directed vector table, backpressure and reset corner
// sequences, then randomized traffic against an arithmetic reference model.
module tb_fp_exp_add_ctrl;

    localparam int BIAS = 15;

    logic       clk = 1'b0;
    logic       rst, in_valid, out_ready, norm_inc;
    logic [4:0] exp_a, exp_b;
    logic       in_ready, out_valid, overflow, underflow;
    logic [4:0] exp_out;
    logic       r_in_ready, r_out_valid, r_overflow, r_underflow;
    logic [4:0] r_exp_out;

    int compared   = 0;
    int mismatched = 0;

    typedef struct {
        logic [4:0] ea;
        logic [4:0] eb;
        logic       inc;
        logic [4:0] e_sat;
        logic       ovf;
        logic       unf;
        logic [4:0] e_raw;
    } vec_t;

    typedef struct {
        logic [4:0] e_sat;
        logic       ovf;
        logic       unf;
        logic [4:0] e_raw;
    } exp_t;

    vec_t tbl [11];
    exp_t sb [$];

    fp_exp_add_ctrl #(.BIAS(BIAS), .SAT(1'b1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .exp_a(exp_a), .exp_b(exp_b), .norm_inc(norm_inc),
        .out_valid(out_valid), .out_ready(out_ready),
        .exp_out(exp_out), .overflow(overflow), .underflow(underflow)
    );

    fp_exp_add_ctrl #(.BIAS(BIAS), .SAT(1'b0)) u_raw (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(r_in_ready),
        .exp_a(exp_a), .exp_b(exp_b), .norm_inc(norm_inc),
        .out_valid(r_out_valid), .out_ready(out_ready),
        .exp_out(r_exp_out), .overflow(r_overflow), .underflow(r_underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic exp_t model(input logic [4:0] a, input logic [4:0] b, input logic inc);
        exp_t m;
        int   t;
        t       = int'(a) + int'(b) - BIAS + int'(inc);
        m.ovf   = (t >= 31);
        m.unf   = (t <= 0);
        m.e_raw = 5'(t & 31);
        m.e_sat = m.ovf ? 5'd31 : (m.unf ? 5'd0 : m.e_raw);
        return m;
    endfunction

    task automatic check_result(input string tag, input logic [4:0] e_sat, input logic ovf,
                                input logic unf, input logic [4:0] e_raw);
        check({tag, " exp_out"}, exp_out, e_sat);
        check({tag, " overflow"}, overflow, ovf);
        check({tag, " underflow"}, underflow, unf);
        check({tag, " raw exp_out"}, r_exp_out, e_raw);
        check({tag, " raw flags"}, {r_overflow, r_underflow}, {ovf, unf});
    endtask

    // Operands are presented just after an edge; the result must be visible
    // after the third following edge (accept, ADD, BIAS).
    task automatic run_vec(input vec_t v, input string tag);
        int lat;
        in_valid  = 1'b1;
        exp_a     = v.ea;
        exp_b     = v.eb;
        norm_inc  = v.inc;
        out_ready = 1'b1;
        #1;
        check({tag, " in_ready"}, in_ready, 1);
        tick;
        in_valid = 1'b0;
        exp_a    = ~v.ea;
        exp_b    = ~v.eb;
        norm_inc = ~v.inc;
        lat      = 1;
        while (!out_valid && lat < 8) begin
            tick;
            lat++;
        end
        check({tag, " latency"}, lat, 3);
        check_result(tag, v.e_sat, v.ovf, v.unf, v.e_raw);
        tick;
        check({tag, " idle after"}, out_valid, 0);
    endtask

    initial begin
        bit   stale;
        exp_t e;

        tbl[0]  = '{5'd15, 5'd15, 1'b0, 5'd15, 1'b0, 1'b0, 5'd15};
        tbl[1]  = '{5'd20, 5'd18, 1'b1, 5'd24, 1'b0, 1'b0, 5'd24};
        tbl[2]  = '{5'd30, 5'd20, 1'b0, 5'd31, 1'b1, 1'b0, 5'd3};
        tbl[3]  = '{5'd8,  5'd7,  1'b0, 5'd0,  1'b0, 1'b1, 5'd0};
        tbl[4]  = '{5'd8,  5'd7,  1'b1, 5'd1,  1'b0, 1'b0, 5'd1};
        tbl[5]  = '{5'd5,  5'd8,  1'b0, 5'd0,  1'b0, 1'b1, 5'd30};
        tbl[6]  = '{5'd0,  5'd0,  1'b0, 5'd0,  1'b0, 1'b1, 5'd17};
        tbl[7]  = '{5'd31, 5'd31, 1'b1, 5'd31, 1'b1, 1'b0, 5'd16};
        tbl[8]  = '{5'd23, 5'd23, 1'b0, 5'd31, 1'b1, 1'b0, 5'd31};
        tbl[9]  = '{5'd23, 5'd22, 1'b1, 5'd31, 1'b1, 1'b0, 5'd31};
        tbl[10] = '{5'd23, 5'd22, 1'b0, 5'd30, 1'b0, 1'b0, 5'd30};

        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        exp_a     = '0;
        exp_b     = '0;
        norm_inc  = 1'b0;
        tick;
        tick;
        rst = 1'b0;
        #1;
        check("reset in_ready", in_ready, 1);
        check("reset out_valid", out_valid, 0);
        check_result("reset", 5'd0, 1'b0, 1'b0, 5'd0);

        for (int i = 0; i < 11; i++) run_vec(tbl[i], $sformatf("vec%0d", i));

        // Backpressure: result parked in HOLD while other operands are offered.
        in_valid  = 1'b1;
        exp_a     = 5'd20;
        exp_b     = 5'd18;
        norm_inc  = 1'b1;
        out_ready = 1'b0;
        tick;
        in_valid = 1'b0;
        tick;
        tick;
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            exp_a     = 5'd1;
            exp_b     = 5'd2;
            norm_inc  = 1'b0;
            out_ready = 1'b0;
            #1;
            check("bp out_valid", out_valid, 1);
            check("bp in_ready", in_ready, 0);
            check("bp hold exp", {exp_out, overflow, underflow}, {5'd24, 2'b00});
            tick;
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        exp_a     = 5'd30;
        exp_b     = 5'd20;
        norm_inc  = 1'b0;
        #1;
        check("bp release in_ready", in_ready, 1);
        tick;
        in_valid = 1'b0;
        exp_a    = 5'd0;
        exp_b    = 5'd0;
        check("b2b add out_valid", out_valid, 0);
        tick;
        check("b2b bias out_valid", out_valid, 0);
        tick;
        check("b2b out_valid", out_valid, 1);
        check_result("b2b", 5'd31, 1'b1, 1'b0, 5'd3);
        tick;

        // Reset while the shared adder is on its bias pass.
        in_valid  = 1'b1;
        exp_a     = 5'd15;
        exp_b     = 5'd15;
        norm_inc  = 1'b0;
        out_ready = 1'b1;
        tick;
        in_valid = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("midrst out_valid", out_valid, 0);
        check("midrst in_ready", in_ready, 1);
        check_result("midrst", 5'd0, 1'b0, 1'b0, 5'd0);
        stale = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (out_valid) stale = 1'b1;
            tick;
        end
        check("midrst no stale", stale, 0);
        run_vec(tbl[1], "post-rst");

        // Randomized traffic against the arithmetic model.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = 1'($urandom_range(0, 1));
            exp_a     = 5'($urandom);
            exp_b     = 5'($urandom);
            norm_inc  = 1'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("rand spurious out_valid", 1, 0);
                end else begin
                    e = sb.pop_front();
                    check_result("rand", e.e_sat, e.ovf, e.unf, e.e_raw);
                end
            end
            if (in_valid && in_ready) sb.push_back(model(exp_a, exp_b, norm_inc));
            tick;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 10 && sb.size() != 0; c++) begin
            #1;
            if (out_valid) begin
                e = sb.pop_front();
                check_result("drain", e.e_sat, e.ovf, e.unf, e.e_raw);
            end
            tick;
        end
        check("rand drained", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
